calc_entry: RTL
===============

Name: calc_entry

Overview:
- Keypad-entry front end for the calculator datapath.
- Converts single-cycle key events into signed decimal operand1/operand2 plus a 3-bit operator code, and drives them into the calculation unit.
- Reads the unit's 32-bit ans back for result chaining and for the entry display.
- Everything is registered on sw_clk; downstream displays read entry_val.

Parameters:
- MAX_DIGITS, 6, maximum decimal digits per positive operand. Negative operands are limited to MAX_DIGITS-1 digits.
- MAG_W, 20, magnitude register width. Must hold 10^MAX_DIGITS-1.

Ports:
- sw_clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- key_valid  in  1  one-cycle key strobe; key_code is sampled when high
- key_code  in  5  0-9 digit, 16 '=', 17 '*', 18 '/', 19 '+', 20 '-', 21 '%', 22 CLR, 23 BKSP, 24 NEG
- ans  in  32  result from the calculation unit; sentinels 0x00CC0000 (null) and 0x00EE0000 (overflow)
- operand1  out  32  signed, sign-extended from magnitude
- operand2  out  32  signed
- operator  out  3  0 null/'=', 1 '*', 2 '/', 3 '+', 4 '-', 5 '%'
- calc_go  out  1  one-cycle pulse when an evaluation is launched
- entry_val  out  32  value to display
- err  out  1  error state flag

Behaviour:
- Reset (async, rst low): state S_A; operand1=0, operand2=0, operator=0, calc_go=0, entry_val=0, err=0; digit counts=0; sign flags=0.
- Keys: no backpressure; one key is accepted per key_valid cycle. Outputs update on the sw_clk edge that samples the key (1-cycle latency). Undefined codes (10-15, 25-31) are ignored.
- States: S_A (entering operand1), S_OP (operator latched), S_B (entering operand2), S_RES (result shown), S_ERR.
- Digit d in S_A or S_B:
  - if count < limit, mag = mag*10 + d and count++;
  - else ignored.
  - Leading zero: mag stays 0 and count does not increment.
- NEG in S_A or S_B: toggles the sign. Toggling to negative is ignored when count == MAX_DIGITS (keeps range -99999..999999).
- Operator key:
  - S_A -> latch op, go to S_OP.
  - S_OP -> replace op.
  - S_B -> ignored.
- Digit in S_OP: operand2 = d, positive, count=1 (0 if d=0); go to S_B.
- '=':
  - In S_B: if op is '/' or '%' and operand2 == 0, go to S_ERR. Otherwise operator = op, calc_go = 1 for one cycle, go to S_RES.
  - In S_A, S_OP, S_RES: ignored.
- S_RES:
  - operator is held; ans is valid 2 edges after entry.
  - Digit -> clear all, operand1 = d, operator = 0, go to S_A.
  - Operator key -> if ans is a sentinel, go to S_ERR. Otherwise operand1 = ans, operand2 = 0, op latched, operator = 0, go to S_OP.
- operator output is 0 in every state except S_RES.
- CLR in any state: same values as reset, applied synchronously.
- S_ERR: err = 1, operator = 0, entry_val = 0x00EE0000. Only CLR (or rst) exits.
- entry_val by state: S_A and S_OP -> operand1; S_B -> operand2; S_RES -> ans.
- Simultaneous rst and key_valid: rst wins.
- rst mid-entry: immediate return to reset values with no partial update.

Optional Feature:
- Macro CALC_BKSP_EN.
- Defined: BKSP in S_A or S_B sets mag = mag/10 and count--. If the result is 0, the sign is cleared. BKSP in S_B with count reaching 0 returns to S_OP. BKSP in S_OP, S_RES, S_ERR is ignored.
- Undefined: code 23 is treated as undefined and ignored. No divider logic is synthesized.

Decomposition:
- Package calc_pkg:
  - key code constants;
  - operator codes 0-5;
  - sentinel constants CALC_NULL=0x00CC0000 and CALC_OVF=0x00EE0000;
  - state encoding;
  - MAX_DIGITS default.
- Sub-module calc_operand_acc, instantiated twice:
  - holds magnitude, sign, digit count;
  - handles digit, NEG, load, clear and BKSP;
  - outputs a signed 32-bit value.

Test Plan:
- Keys 1,2,3,'+',4,5,'=' -> operand1=123, operand2=45, operator=3, calc_go high exactly 1 cycle; ans=168 within 2 edges; entry_val=168.
- Seven '9' keys -> operand1=999999 (7th ignored). NEG then ignored. CLR, five '9' keys, NEG -> operand1=-99999.
- Keys 8,'/',0,'=' -> err=1, operator=0, entry_val=0x00EE0000, calc_go stays 0. Further digits ignored. CLR -> all outputs 0, state S_A.
- Keys 6,'*',7,'=' (ans=42), then '-',2,'=' -> operand1=42, operand2=2, operator=4, ans=40. Forcing ans=0x00EE0000 then '+' -> err=1.
- rst pulled low in S_B after 4,'+',3 -> all outputs 0 asynchronously, before the next edge. Keys after release start fresh in S_A.
- With CALC_BKSP_EN: 1,2,3,BKSP -> operand1=12; '+',5,BKSP -> state S_OP, operand2=0. Without the macro: BKSP leaves operand1=123.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants for the calculator keypad entry front end.
// Optional backspace support is built when CALC_BKSP_EN is defined.
package calc_pkg;

    localparam int CALC_MAX_DIGITS = 6;
    localparam int CALC_MAG_W      = 20;

    localparam logic [4:0] KEY_EQ   = 5'd16;
    localparam logic [4:0] KEY_MUL  = 5'd17;
    localparam logic [4:0] KEY_DIV  = 5'd18;
    localparam logic [4:0] KEY_ADD  = 5'd19;
    localparam logic [4:0] KEY_SUB  = 5'd20;
    localparam logic [4:0] KEY_MOD  = 5'd21;
    localparam logic [4:0] KEY_CLR  = 5'd22;
    localparam logic [4:0] KEY_BKSP = 5'd23;
    localparam logic [4:0] KEY_NEG  = 5'd24;

    localparam logic [2:0] OP_NULL = 3'd0;
    localparam logic [2:0] OP_MUL  = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_MOD  = 3'd5;

    localparam logic [31:0] CALC_NULL = 32'h00CC_0000;
    localparam logic [31:0] CALC_OVF  = 32'h00EE_0000;

    typedef enum logic [2:0] {
        S_A   = 3'd0,
        S_OP  = 3'd1,
        S_B   = 3'd2,
        S_RES = 3'd3,
        S_ERR = 3'd4
    } calc_state_t;

    function automatic logic is_sentinel(input logic [31:0] v);
        return (v == CALC_NULL) || (v == CALC_OVF);
    endfunction

endpackage

// File: rtl/calc_entry_operand_acc.sv
// Decimal operand accumulator: magnitude, sign and digit count, presented as a signed value.
// Backspace (divide by ten) logic exists only when CALC_BKSP_EN is defined.
module calc_operand_acc
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = CALC_MAX_DIGITS,
    parameter int MAG_W      = CALC_MAG_W,
    localparam int CNT_W     = $clog2(MAX_DIGITS + 1)
) (
    input  logic             sw_clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [31:0]      load_val,
    input  logic             digit_en,
    input  logic [3:0]       digit,
    input  logic             neg_en,
    input  logic             bksp_en,
    output logic [31:0]      value,
    output logic [CNT_W-1:0] count
);

    logic [MAG_W-1:0] mag_q, mag_d;
    logic             neg_q, neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, limit;
    logic [31:0]      val_q, val_d;
    logic             upd;

    // clr acts first so that "clear then enter digit" happens in one key cycle
    always_comb begin
        mag_d = clr ? '0 : mag_q;
        neg_d = clr ? 1'b0 : neg_q;
        cnt_d = clr ? '0 : cnt_q;
        upd   = clr;
        limit = neg_d ? CNT_W'(MAX_DIGITS - 1) : CNT_W'(MAX_DIGITS);
        if (digit_en) begin
            upd = 1'b1;
            if ((cnt_d < limit) && !((mag_d == '0) && (digit == 4'd0))) begin
                mag_d = mag_d * MAG_W'(10) + MAG_W'(digit);
                cnt_d = cnt_d + 1'b1;
            end
        end
        if (neg_en) begin
            upd = 1'b1;
            if (neg_d || (cnt_d != CNT_W'(MAX_DIGITS)))
                neg_d = !neg_d;
        end
`ifdef CALC_BKSP_EN
        if (bksp_en) begin
            upd = 1'b1;
            if (cnt_d != '0) begin
                mag_d = mag_d / MAG_W'(10);
                cnt_d = cnt_d - 1'b1;
            end
            if (mag_d == '0)
                neg_d = 1'b0;
        end
`endif
        // A loaded result is not digit-editable, so the count is pinned at full
        if (load) begin
            mag_d = '0;
            neg_d = 1'b0;
            cnt_d = CNT_W'(MAX_DIGITS);
        end
        if (load)
            val_d = load_val;
        else if (upd)
            val_d = neg_d ? -(32'(mag_d)) : 32'(mag_d);
        else
            val_d = val_q;
    end

`ifndef CALC_BKSP_EN
    logic unused_bksp;
    assign unused_bksp = bksp_en;
`endif

    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            mag_q <= '0;
            neg_q <= 1'b0;
            cnt_q <= '0;
            val_q <= '0;
        end else begin
            mag_q <= mag_d;
            neg_q <= neg_d;
            cnt_q <= cnt_d;
            val_q <= val_d;
        end
    end

    assign value = val_q;
    assign count = cnt_q;

endmodule

// File: rtl/calc_entry.sv
// Keypad entry front end: builds operand1/operand2/operator for the calculation unit.
// Define CALC_BKSP_EN to enable the backspace key (code 23).
//
// state | meaning
// S_A   | entering operand1
// S_OP  | operator latched, waiting for operand2
// S_B   | entering operand2
// S_RES | result shown, operator driven
// S_ERR | error; only CLR exits
module calc_entry
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = CALC_MAX_DIGITS,
    parameter int MAG_W      = CALC_MAG_W
) (
    input  logic        sw_clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    input  logic [31:0] ans,
    output logic [31:0] operand1,
    output logic [31:0] operand2,
    output logic [2:0]  operator,
    output logic        calc_go,
    output logic [31:0] entry_val,
    output logic        err
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    calc_state_t      state_q, state_d;
    logic [2:0]       op_q, op_d, key_op;
    logic             go_d, calc_go_q;
    logic             is_digit, is_op, is_eq, is_clr, is_neg, is_bksp;
    logic             div_zero, ans_ok;
    logic             clr_a, dig_a, neg_a, bksp_a, ld_a;
    logic             clr_b, dig_b, neg_b, bksp_b;
    logic [CNT_W-1:0] unused_cnt_a, cnt_b;

    assign is_digit = key_valid && (key_code <= 5'd9);
    assign is_op    = key_valid && (key_code >= KEY_MUL) && (key_code <= KEY_MOD);
    assign is_eq    = key_valid && (key_code == KEY_EQ);
    assign is_clr   = key_valid && (key_code == KEY_CLR);
    assign is_neg   = key_valid && (key_code == KEY_NEG);
`ifdef CALC_BKSP_EN
    assign is_bksp  = key_valid && (key_code == KEY_BKSP);
`else
    assign is_bksp  = 1'b0;
`endif
    assign key_op   = 3'(key_code - KEY_EQ);
    assign div_zero = ((op_q == OP_DIV) || (op_q == OP_MOD)) && (operand2 == 32'd0);
    assign ans_ok   = !is_sentinel(ans);

    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_A;
            op_q      <= OP_NULL;
            calc_go_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            calc_go_q <= go_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        go_d    = 1'b0;
        if (is_clr) begin
            state_d = S_A;
            op_d    = OP_NULL;
        end else begin
            case (state_q)
                S_A: if (is_op) begin
                    op_d    = key_op;
                    state_d = S_OP;
                end
                S_OP: begin
                    if (is_op)
                        op_d = key_op;
                    else if (is_digit)
                        state_d = S_B;
                end
                S_B: begin
                    if (is_eq) begin
                        if (div_zero) begin
                            state_d = S_ERR;
                        end else begin
                            go_d    = 1'b1;
                            state_d = S_RES;
                        end
                    end else if (is_bksp && (cnt_b <= CNT_W'(1))) begin
                        state_d = S_OP;
                    end
                end
                S_RES: begin
                    if (is_digit) begin
                        op_d    = OP_NULL;
                        state_d = S_A;
                    end else if (is_op) begin
                        if (ans_ok) begin
                            op_d    = key_op;
                            state_d = S_OP;
                        end else begin
                            state_d = S_ERR;
                        end
                    end
                end
                S_ERR:   ;
                default: state_d = S_A;
            endcase
        end
    end

    always_comb begin
        clr_a     = is_clr;
        dig_a     = 1'b0;
        neg_a     = 1'b0;
        bksp_a    = 1'b0;
        ld_a      = 1'b0;
        clr_b     = is_clr;
        dig_b     = 1'b0;
        neg_b     = 1'b0;
        bksp_b    = 1'b0;
        operator  = OP_NULL;
        err       = 1'b0;
        entry_val = operand1;
        case (state_q)
            S_A: begin
                dig_a  = is_digit;
                neg_a  = is_neg;
                bksp_a = is_bksp;
            end
            S_OP: begin
                clr_b = is_clr || is_digit;
                dig_b = is_digit;
            end
            S_B: begin
                dig_b     = is_digit;
                neg_b     = is_neg;
                bksp_b    = is_bksp;
                entry_val = operand2;
            end
            S_RES: begin
                operator  = op_q;
                entry_val = ans;
                clr_a     = is_clr || is_digit;
                dig_a     = is_digit;
                ld_a      = is_op && ans_ok;
                clr_b     = is_clr || is_digit || (is_op && ans_ok);
            end
            S_ERR: begin
                err       = 1'b1;
                entry_val = CALC_OVF;
            end
            default: ;
        endcase
    end

    assign calc_go = calc_go_q;

    calc_operand_acc #(.MAX_DIGITS(MAX_DIGITS), .MAG_W(MAG_W)) u_acc_a (
        .sw_clk   (sw_clk),
        .rst      (rst),
        .clr      (clr_a),
        .load     (ld_a),
        .load_val (ans),
        .digit_en (dig_a),
        .digit    (key_code[3:0]),
        .neg_en   (neg_a),
        .bksp_en  (bksp_a),
        .value    (operand1),
        .count    (unused_cnt_a)
    );

    calc_operand_acc #(.MAX_DIGITS(MAX_DIGITS), .MAG_W(MAG_W)) u_acc_b (
        .sw_clk   (sw_clk),
        .rst      (rst),
        .clr      (clr_b),
        .load     (1'b0),
        .load_val (32'd0),
        .digit_en (dig_b),
        .digit    (key_code[3:0]),
        .neg_en   (neg_b),
        .bksp_en  (bksp_b),
        .value    (operand2),
        .count    (cnt_b)
    );

endmodule
